satd_transpose_buffer: RTL

4x4 ping-pong transpose buffer between the row (horizontal) Hadamard pass and the column (vertical) Hadamard pass of the SATD datapath. It accepts one transformed row of four signed coefficients per cycle and returns the same block column by column. With two banks, one block can be filled while the other is drained, so sustained throughput is one row in and one column out per cycle.

---
 rtl/satd_pkg.sv | 14 +
 rtl/satd_tp_bank.sv | 35 +++
 rtl/satd_transpose_buffer.sv | 88 ++++++++
 3 files changed

// File: rtl/satd_pkg.sv
// Shared types for the SATD Hadamard datapath.
// Row and column passes exchange vec_t bundles of signed coefficients.
package satd_pkg;

  localparam int N     = 4;
  localparam int DW    = 11;
  localparam int IDX_W = 2;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

  typedef logic signed [DW-1:0] coef_t;
  typedef coef_t [N-1:0]        vec_t;

endpackage

// File: rtl/satd_tp_bank.sv
// One 4x4 coefficient bank: row-wide write port,
// combinational column-wide read port.
module satd_tp_bank
  import satd_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [IDX_W-1:0] wrow,
  input  vec_t             wdata,
  input  logic [IDX_W-1:0] rcol,
  output vec_t             rdata
);

  vec_t mem [N];

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int r = 0; r < N; r++) begin
        mem[r] <= '0;
      end
    end else if (we) begin
      mem[wrow] <= wdata;
    end
  end

  // element r of the column comes from row r
  always_comb begin
    rdata = '0;
    for (int r = 0; r < N; r++) begin
      rdata[r] = mem[r][rcol];
    end
  end

endmodule

// File: rtl/satd_transpose_buffer.sv
// Ping-pong 4x4 transpose buffer between the row and
// column Hadamard passes of the SATD datapath.
module satd_transpose_buffer #(
  parameter int DW = satd_pkg::DW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [4*DW-1:0] in_row,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [4*DW-1:0] out_col,
  output logic [1:0]    out_idx,
  output logic          out_last
);

  logic       wbank;
  logic       rbank;
  logic [1:0] wrow;
  logic [1:0] rcol;
  logic [1:0] full;
  logic [1:0] full_n;
  logic       wr;
  logic       rd;

  satd_pkg::vec_t wdata;
  satd_pkg::vec_t rdata [2];

  assign in_ready  = !full[wbank];
  assign out_valid = full[rbank];
  assign wr        = in_valid && in_ready;
  assign rd        = out_valid && out_ready;
  assign wdata     = in_row;
  assign out_col   = rdata[rbank];
  assign out_idx   = rcol;
  assign out_last  = out_valid &&
                     (rcol == satd_pkg::LAST_IDX);

  for (genvar b = 0; b < 2; b++) begin : g_bank
    satd_tp_bank u_bank (
      .clk   (clk),
      .rst   (rst),
      .we    (wr && (wbank == 1'(b))),
      .wrow  (wrow),
      .wdata (wdata),
      .rcol  (rcol),
      .rdata (rdata[b])
    );
  end

  // write and read always target different banks,
  // so set and clear never collide on one flag
  always_comb begin
    full_n = full;
    if (wr && (wrow == satd_pkg::LAST_IDX)) begin
      full_n[wbank] = 1'b1;
    end
    if (rd && (rcol == satd_pkg::LAST_IDX)) begin
      full_n[rbank] = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wbank <= 1'b0;
      wrow  <= '0;
      rbank <= 1'b0;
      rcol  <= '0;
      full  <= '0;
    end else begin
      full <= full_n;
      if (wr) begin
        wrow <= wrow + 2'd1;
        if (wrow == satd_pkg::LAST_IDX) begin
          wbank <= ~wbank;
        end
      end
      if (rd) begin
        rcol <= rcol + 2'd1;
        if (rcol == satd_pkg::LAST_IDX) begin
          rbank <= ~rbank;
        end
      end
    end
  end

endmodule
